// File: rtl/rank_sort_frame_pkg.sv
// sort_pkg: shared types and helpers for rank_sort_frame.
//   sort_state_t : LOAD / RANK / EMIT controller states
//   MAX_N        : largest supported frame length
//   cnt_w(n)     : width of cnt/ptr/i counters, able to hold 0..n
package sort_pkg;
  localparam int MAX_N = 64;
  typedef enum logic [1:0] {LOAD, RANK, EMIT} sort_state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/rank_sort_frame_if.sv
// rank_sort_frame_if: input/output streams of the frame sorter.
//   master : producer/consumer side (drives descend, in_*, out_ready)
//   slave  : sorter side (drives in_ready, out_*, busy)
//   out_index exists only when SORT_INDEX_EN is defined.
interface rank_sort_frame_if #(parameter int N = 8, parameter int WIDTH = 8);
  logic             descend;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
`ifdef SORT_INDEX_EN
  logic [$clog2(N)-1:0] out_index;
  modport master (output descend, in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last, busy, out_index);
  modport slave (input descend, in_valid, in_data, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_last, busy, out_index);
`else
  modport master (output descend, in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last, busy);
  modport slave (input descend, in_valid, in_data, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_last, busy);
`endif
endinterface

// File: rtl/sort_rank_unit.sv
// sort_rank_unit: combinational stable rank of keys_i[idx_i] within the first len_i keys.
//   keys_i : frame buffer      len_i : frame length L
//   idx_i  : element to rank  mode_i : 1 = descending
//   rank_o : destination slot of that element in the sorted frame
module sort_rank_unit import sort_pkg::*; #(
  parameter int N = 8,
  parameter int WIDTH = 8,
  parameter int CW = cnt_w(N),
  parameter int IW = $clog2(N)
) (
  input  logic [WIDTH-1:0] keys_i [N],
  input  logic [CW-1:0]    len_i,
  input  logic [CW-1:0]    idx_i,
  input  logic             mode_i,
  output logic [IW-1:0]    rank_o
);
  logic [WIDTH-1:0] key;
  always_comb begin
    key = keys_i[idx_i[IW-1:0]];
    rank_o = '0;
    // equal keys that arrived earlier rank first, which keeps the sort stable
    for (int j = 0; j < N; j++)
      if (CW'(j) < len_i && ((mode_i ? keys_i[j] > key : keys_i[j] < key) ||
                             (keys_i[j] == key && CW'(j) < idx_i)))
        rank_o = rank_o + IW'(1);
  end
endmodule

// File: rtl/rank_sort_frame.sv
// rank_sort_frame: stable rank-count sorter for frames of up to N unsigned words.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rank_sort_frame_if.slave (descend, in_valid/in_ready/in_data/in_last,
//              out_valid/out_ready/out_data/out_last, busy)
//   SORT_INDEX_EN : adds bus.out_index, the arrival position of each sorted word.
module rank_sort_frame import sort_pkg::*; #(
  parameter int N = 8,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  rank_sort_frame_if.slave bus
);
  localparam int CW = cnt_w(N);
  localparam int IW = $clog2(N);
  sort_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, ptr_q, ptr_d;
  logic mode_q, mode_d, accept, handshake;
  logic [IW-1:0] rank;
  logic [WIDTH-1:0] keys_q [N];
  logic [WIDTH-1:0] sorted_q [N];
  assign accept = bus.in_valid & bus.in_ready;
  assign handshake = bus.out_valid & bus.out_ready;
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy = state_q != LOAD;
  assign bus.out_valid = state_q == EMIT;
  assign bus.out_last = bus.out_valid && ptr_q == cnt_q - CW'(1);
  assign bus.out_data = bus.out_valid ? sorted_q[ptr_q[IW-1:0]] : '0;
  sort_rank_unit #(.N(N), .WIDTH(WIDTH), .CW(CW), .IW(IW)) u_rank (
    .keys_i(keys_q), .len_i(cnt_q), .idx_i(idx_q), .mode_i(mode_q), .rank_o(rank)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    mode_d = mode_q;
    case (state_q)
      LOAD: if (accept) begin
        cnt_d = cnt_q + CW'(1);
        mode_d = cnt_q == '0 ? bus.descend : mode_q;
        if (bus.in_last || cnt_q == CW'(N - 1)) begin
          state_d = RANK;
          idx_d = '0;
        end
      end
      RANK: begin
        idx_d = idx_q + CW'(1);
        if (idx_q == cnt_q - CW'(1)) begin
          state_d = EMIT;
          ptr_d = '0;
        end
      end
      default: if (handshake) begin
        ptr_d = ptr_q + CW'(1);
        if (bus.out_last) begin
          state_d = LOAD;
          cnt_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      cnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      mode_q <= mode_d;
    end
  always_ff @(posedge clk) begin
    if (accept) keys_q[cnt_q[IW-1:0]] <= bus.in_data;
    if (state_q == RANK) sorted_q[rank] <= keys_q[idx_q[IW-1:0]];
  end
`ifdef SORT_INDEX_EN
  logic [IW-1:0] index_q [N];
  assign bus.out_index = bus.out_valid ? index_q[ptr_q[IW-1:0]] : '0;
  always_ff @(posedge clk)
    if (state_q == RANK) index_q[rank] <= idx_q[IW-1:0];
`endif
endmodule

// File: tb/tb_rank_sort_frame.sv
// tb_rank_sort_frame: scoreboard bench for rank_sort_frame against a selection-sort model.
module tb_rank_sort_frame;
  localparam int N = 8;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rank_sort_frame_if #(.N(N), .WIDTH(W)) bus();
  rank_sort_frame #(.N(N), .WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic [W-1:0] d; logic l; int idx;} exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0, cyc = 0, close_cyc = 0, exp_lat = 0, rdy_mode = 0;
  logic pv = 1'b0, stalled = 1'b0, sl;
  logic [W-1:0] sd;
  int si;
  logic [W-1:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: repeatedly pick the best remaining key, earliest arrival on ties
  function automatic void push_model(input logic [W-1:0] k[$], input logic desc);
    bit used[N];
    int best;
    for (int p = 0; p < k.size(); p++) begin
      best = -1;
      for (int j = 0; j < k.size(); j++)
        if (!used[j] && (best < 0 || (desc ? k[j] > k[best] : k[j] < k[best]))) best = j;
      used[best] = 1'b1;
      sb.push_back('{d: k[best], l: p == k.size() - 1, idx: best});
    end
  endfunction

  task automatic send_frame(input logic [W-1:0] k[$], input logic desc, input bit gaps);
    int w;
    for (int n = 0; n < k.size(); n++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.in_valid = 1'b1;
      bus.in_data = k[n];
      bus.in_last = n == k.size() - 1;
      bus.descend = n == 0 ? desc : 1'($urandom_range(0, 1));
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 500) begin @(negedge clk); w++; end
      if (w >= 500) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        $fatal(1);
      end
      if (n == k.size() - 1) begin
        close_cyc = cyc;
        exp_lat = k.size() + 1;
        push_model(k, desc);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 3000) begin @(posedge clk); w++; end
    check("drain_remaining", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_busy"}, bus.busy, 0);
`ifdef SORT_INDEX_EN
    check({tag, "_out_index"}, bus.out_index, 0);
`endif
  endtask

  initial begin
    int k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
    end
  end

  always @(negedge clk)
    if (rst) begin
      pv = 1'b0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, sd);
        check("stall_last", bus.out_last, sl);
`ifdef SORT_INDEX_EN
        check("stall_index", bus.out_index, si);
`endif
      end
      if (bus.out_valid && !pv) check("first_valid_latency", cyc - close_cyc, exp_lat);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_last", bus.out_last, e.l);
`ifdef SORT_INDEX_EN
          check("out_index", bus.out_index, e.idx);
`endif
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sl = bus.out_last;
`ifdef SORT_INDEX_EN
      si = bus.out_index;
`else
      si = 0;
`endif
      pv = bus.out_valid;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    logic d;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.descend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    q = {8'd5, 8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd8, 8'd4};
    send_frame(q, 1'b0, 1'b0);
    drain();
    q = {8'd4, 8'd4, 8'd2, 8'd9};
    send_frame(q, 1'b1, 1'b0);
    drain();
    q = {8'hA5};
    send_frame(q, 1'b0, 1'b0);
    drain();
    rdy_mode = 1;
    q = {8'd10, 8'd200, 8'd10, 8'd0, 8'd77, 8'd3, 8'd200, 8'd1};
    send_frame(q, 1'b1, 1'b0);
    drain();
    rdy_mode = 0;
    q = {8'hFF, 8'h00, 8'hFF, 8'h00};
    send_frame(q, 1'b0, 1'b0);
    drain();
    q = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    send_frame(q, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check_idle("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("after_abort");
    q = {8'd9, 8'd1, 8'd5};
    send_frame(q, 1'b0, 1'b0);
    drain();
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, N);
      d = 1'($urandom_range(0, 1));
      q.delete();
      for (int n = 0; n < len; n++)
        q.push_back(f % 2 == 0 ? W'($urandom_range(0, 3)) : W'($urandom_range(0, 255)));
      send_frame(q, d, 1'b1);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rank_sort_frame.md
# rank_sort_frame

Parametrised, handshaked successor to the team's fixed-size FSM sorter. It accepts a frame of up to N unsigned words over a valid/ready stream and sorts them stably by rank counting, one element ranked per cycle. It then streams the sorted frame out with a last marker. Ascending or descending order is selected per frame. It sits between a sample-capture buffer and downstream statistics (median/percentile) logic.

## Interface
- N, default 8: maximum frame length; legal range 2..64.
- WIDTH, default 8: key width in bits, unsigned.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- descend  in  1  order select; sampled with the first accepted word of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input key.
- in_last  in  1  marks the final word of a frame shorter than N.
- out_valid  out  1  sorted word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  sorted key.
- out_last  out  1  final word of the sorted frame.
- busy  out  1  high in the RANK and EMIT states.

## Operation
- States: LOAD, RANK, EMIT. Reset state is LOAD.
- LOAD:
  - in_ready=1. A word is accepted when in_valid&in_ready; it is stored at buf[cnt] and cnt increments.
  - The mode register is loaded from descend on the first accept (cnt==0).
  - Go to RANK on the accept that has in_last=1 or that makes cnt==N. The frame length L equals cnt after that accept, 1..N.
  - in_last is ignored once cnt reaches N; an N-word frame always closes at the N-th word.
- RANK: one element i per cycle, i=0..L-1.
  - Ascending rank(i) = #{j<L : buf[j]<buf[i]} + #{j<i : buf[j]==buf[i]}.
  - Descending uses > in place of <.
  - sorted[rank(i)] <= buf[i].
  - After i=L-1, go to EMIT with ptr=0.
  - The ranks form a permutation of 0..L-1. Sorting is stable, and duplicates keep arrival order.
- EMIT:
  - out_valid=1, out_data=sorted[ptr], out_last=(ptr==L-1).
  - On out_valid&out_ready, ptr increments.
  - The handshake with out_last returns the block to LOAD, clearing cnt.
  - out_data/out_last must stay stable while out_valid&~out_ready.
- Counters cnt, ptr and i are $clog2(N+1) bits wide. Comparisons are unsigned, full WIDTH.
- Reset mid-frame: all state is discarded, the block returns to LOAD with cnt=0, and no partial output is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. buf/sorted contents are don't-care.
- All outputs are registered or decoded from registered state. There is no combinational in→out path.
- One word accepted per cycle in LOAD. in_ready=0 in RANK and EMIT.
- The state is RANK from the edge after the closing accept. It is RANK for exactly L cycles, then EMIT.
- First out_valid is seen L+1 cycles after the cycle of the closing accept.
- Full throughput in EMIT: one word per cycle while out_ready=1.
- in_ready is 1 in the cycle after the out_last handshake. There is no overlap between frames.

## Configuration
- SORT_INDEX_EN defined: the block adds port out_index (out, $clog2(N) bits) carrying the original arrival position of out_data. That index is stored alongside sorted[] in RANK. out_index resets to 0 and holds with out_data under backpressure.
- SORT_INDEX_EN undefined: the out_index port and its storage are absent. All other behaviour is identical.

## Structure
- Package sort_pkg holds:
  - state typedef sort_state_t {LOAD, RANK, EMIT};
  - helper function for counter width ($clog2(N+1));
  - a localparam for the maximum legal N.
- Sub-module sort_rank_unit:
  - combinational;
  - inputs buf[], L, i, mode;
  - output rank(i);
  - instantiated once, with the top FSM driving i.

## Test plan
- Ascending, N=8, input 5,3,7,1,9,2,8,4 (in_last on 8th word) -> output 1,2,3,4,5,7,8,9. out_last on the 8th output. First out_valid 9 cycles after the last accept.
- Descending with duplicates 4,4,2,9 (L=4, in_last on 4th word) -> 9,4,4,2. With SORT_INDEX_EN, out_index = 3,0,1,2.
- Short frame L=1 (value 0xA5, in_last=1) -> a single output 0xA5 with out_last=1 after 2 cycles.
- Backpressure: out_ready toggled 1,0,0,1,... during EMIT -> no word lost or repeated, and outputs are stable while stalled.
- Extremes WIDTH=8: 0xFF,0x00,0xFF,0x00 ascending -> 0x00,0x00,0xFF,0xFF. Unsigned compare confirmed.
- Reset asserted during RANK of a 6-word frame -> out_valid=0, in_ready=1 after reset. A new 3-word frame then sorts correctly, with no residue from the aborted frame.
